// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: valid/ready issue and response controller in front of the Booth multiplier, with a one-entry last-result cache
module mult_issue_ctrl #(
   parameter int length   = 32,
   parameter bit CACHE_EN = 1'b1,
   parameter int MAX_WAIT = 15
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic [length-1:0] REQ_A,
   input  logic [length-1:0] REQ_B,
   input  logic              REQ_HIGH,
   input  logic              FLUSH,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [length-1:0] RSP_DATA,
   output logic              RSP_ERR,
   output logic [length-1:0] OPER_A,
   output logic [length-1:0] OPER_B,
   output logic              FUCT3,
   output logic              ENABLE_MULT,
   input  logic [length-1:0] MULT_O,
   input  logic              MULT_FINISH
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2;
   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [length-1:0] a_q, b_q, c_a, c_b, c_d, rsp_d;
   logic              high_q, c_h, c_vld, rsp_e;
   logic              accept, hit;
   assign REQ_READY   = state == IDLE && !FLUSH;
   assign accept      = REQ_VALID && REQ_READY;
   assign hit         = CACHE_EN && c_vld && REQ_A == c_a && REQ_B == c_b && REQ_HIGH == c_h;
   assign RSP_VALID   = state == RESP;
   assign ENABLE_MULT = state == RUN;
   assign RSP_DATA    = rsp_d;
   assign RSP_ERR     = rsp_e;
   assign OPER_A      = a_q;
   assign OPER_B      = b_q;
   assign FUCT3       = high_q;
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         high_q <= 1'b0;
         rsp_d  <= '0;
         rsp_e  <= 1'b0;
         c_a    <= '0;
         c_b    <= '0;
         c_d    <= '0;
         c_h    <= 1'b0;
         c_vld  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_q    <= REQ_A;
               b_q    <= REQ_B;
               high_q <= REQ_HIGH;
               if (hit) begin
                  rsp_d <= c_d;
                  rsp_e <= 1'b0;
                  state <= RESP;
               end else begin
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            // flush outranks a same-cycle finish so an abandoned result never reaches the cache
            RUN: if (FLUSH) begin
               state <= IDLE;
            end else if (MULT_FINISH) begin
               rsp_d <= MULT_O;
               rsp_e <= 1'b0;
               c_a   <= a_q;
               c_b   <= b_q;
               c_h   <= high_q;
               c_d   <= MULT_O;
               c_vld <= 1'b1;
               state <= RESP;
            end else if (cnt == CW'(MAX_WAIT)) begin
               rsp_d <= '0;
               rsp_e <= 1'b1;
               state <= RESP;
            end else begin
               cnt <= cnt + 1'b1;
            end
            RESP: if (FLUSH || RSP_READY) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: directed vector table plus hand sequences for flush, backpressure and mid-run reset
module tb_mult_issue_ctrl;
   logic        clk = 1'b0;
   logic        RST_N = 1'b0;
   logic        REQ_VALID = 1'b0, REQ_HIGH = 1'b0, FLUSH = 1'b0, RSP_READY = 1'b0;
   logic [31:0] REQ_A = '0, REQ_B = '0;
   logic        REQ_READY, RSP_VALID, RSP_ERR, FUCT3, ENABLE_MULT, MULT_FINISH;
   logic [31:0] RSP_DATA, OPER_A, OPER_B, MULT_O;
   logic        hang = 1'b0, inj = 1'b0;
   logic [1:0]  en_cnt;
   logic [63:0] prod;
   int          errors = 0, checks = 0;

   mult_issue_ctrl dut (
      .CLK(clk), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_HIGH(REQ_HIGH), .FLUSH(FLUSH),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
      .OPER_A(OPER_A), .OPER_B(OPER_B), .FUCT3(FUCT3), .ENABLE_MULT(ENABLE_MULT),
      .MULT_O(MULT_O), .MULT_FINISH(MULT_FINISH)
   );

   always #5 clk = ~clk;

   // multiplier stub: finishes in the third enabled cycle unless hung; inj forces a stray finish
   always_ff @(posedge clk or negedge RST_N)
      if (!RST_N) en_cnt <= '0;
      else en_cnt <= ENABLE_MULT ? en_cnt + 2'd1 : 2'd0;
   assign prod        = {32'b0, OPER_A} * {32'b0, OPER_B};
   assign MULT_O      = FUCT3 ? prod[63:32] : prod[31:0];
   assign MULT_FINISH = (ENABLE_MULT && en_cnt == 2'd2 && !hang) || inj;

   typedef struct {
      logic [31:0] a, b;
      logic        high, hang;
      int          hold;
      logic [31:0] data;
      logic        err;
      int          en, lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] b, input logic h,
                         input int hold, input logic [31:0] ed, input logic ee, input int een, input int elat);
      int en, lat;
      @(negedge clk);
      chk({tag, "_ready_pre"}, REQ_READY, 1);
      REQ_A = a; REQ_B = b; REQ_HIGH = h; REQ_VALID = 1'b1;
      @(negedge clk);
      REQ_VALID = 1'b0;
      lat = 1; en = 0;
      while (!RSP_VALID && lat < 40) begin
         en += int'(ENABLE_MULT);
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_en"}, en, een);
      chk({tag, "_data"}, RSP_DATA, ed);
      chk({tag, "_err"}, RSP_ERR, ee);
      for (int k = 0; k < hold; k++) begin
         REQ_A = 32'd1; REQ_B = 32'd1; REQ_VALID = 1'b1;
         @(negedge clk);
         chk({tag, "_hold_valid"}, RSP_VALID, 1);
         chk({tag, "_hold_data"}, RSP_DATA, ed);
         chk({tag, "_hold_ready"}, REQ_READY, 0);
      end
      REQ_VALID = 1'b0;
      RSP_READY = 1'b1;
      @(negedge clk);
      RSP_READY = 1'b0;
      chk({tag, "_ready_post"}, REQ_READY, 1);
      chk({tag, "_rsp_drop"}, RSP_VALID, 0);
      chk({tag, "_no_stray_run"}, ENABLE_MULT, 0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{32'd7, 32'd6, 1'b0, 1'b0, 0, 32'd42, 1'b0, 3, 4};
      vecs[1] = '{32'd7, 32'd6, 1'b0, 1'b0, 0, 32'd42, 1'b0, 0, 1};
      vecs[2] = '{32'd7, 32'd6, 1'b1, 1'b0, 0, 32'd0, 1'b0, 3, 4};
      vecs[3] = '{32'd7, 32'd6, 1'b1, 1'b0, 0, 32'd0, 1'b0, 0, 1};
      vecs[4] = '{32'h10000, 32'h30000, 1'b1, 1'b0, 0, 32'd3, 1'b0, 3, 4};
      vecs[5] = '{32'h10000, 32'h30000, 1'b0, 1'b0, 0, 32'd0, 1'b0, 3, 4};
      vecs[6] = '{32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 0, 32'hFFFFFFFE, 1'b0, 3, 4};
      vecs[7] = '{32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 5, 32'hFFFFFFFE, 1'b0, 0, 1};
      vecs[8] = '{32'd5, 32'd5, 1'b0, 1'b1, 0, 32'd0, 1'b1, 16, 17};
      vecs[9] = '{32'd5, 32'd5, 1'b0, 1'b0, 0, 32'd25, 1'b0, 3, 4};
      #2;
      chk("rst_req_ready", REQ_READY, 1);
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_enable", ENABLE_MULT, 0);
      chk("rst_rsp_data", RSP_DATA, 0);
      chk("rst_rsp_err", RSP_ERR, 0);
      chk("rst_oper_a", OPER_A, 0);
      chk("rst_fuct3", FUCT3, 0);
      @(negedge clk);
      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         hang = vecs[i].hang;
         do_req($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].high, vecs[i].hold,
                vecs[i].data, vecs[i].err, vecs[i].en, vecs[i].lat);
      end
      hang = 1'b0;
      // flush in the second RUN cycle, then a stray finish and a flushed request in IDLE
      @(negedge clk);
      REQ_A = 32'd9; REQ_B = 32'd9; REQ_HIGH = 1'b0; REQ_VALID = 1'b1;
      @(negedge clk);
      REQ_VALID = 1'b0;
      chk("flush_run1_en", ENABLE_MULT, 1);
      @(negedge clk);
      chk("flush_run2_en", ENABLE_MULT, 1);
      FLUSH = 1'b1;
      @(negedge clk);
      chk("flush_idle_en", ENABLE_MULT, 0);
      chk("flush_no_rsp", RSP_VALID, 0);
      chk("flush_blocks_ready", REQ_READY, 0);
      REQ_A = 32'd2; REQ_B = 32'd2; REQ_VALID = 1'b1; inj = 1'b1;
      @(negedge clk);
      chk("flush_blocked_accept", ENABLE_MULT, 0);
      chk("late_finish_ignored", RSP_VALID, 0);
      FLUSH = 1'b0; REQ_VALID = 1'b0; inj = 1'b0;
      #1 chk("flush_ready_back", REQ_READY, 1);
      do_req("after_flush", 32'd9, 32'd9, 1'b0, 0, 32'd81, 1'b0, 3, 4);
      // asynchronous reset in the middle of a run invalidates the cache
      @(negedge clk);
      REQ_A = 32'd4; REQ_B = 32'd4; REQ_VALID = 1'b1;
      @(negedge clk);
      REQ_VALID = 1'b0;
      @(negedge clk);
      chk("midrun_en", ENABLE_MULT, 1);
      RST_N = 1'b0;
      #1;
      chk("rst_midrun_en", ENABLE_MULT, 0);
      chk("rst_midrun_ready", REQ_READY, 1);
      chk("rst_midrun_rsp", RSP_VALID, 0);
      @(negedge clk);
      RST_N = 1'b1;
      do_req("after_reset", 32'd9, 32'd9, 1'b0, 0, 32'd81, 1'b0, 3, 4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
